// File: rtl/shake_sponge_ctrl.sv
// SHAKE sponge sequencer: clear -> absorb rate words -> 24 rounds -> squeeze, with all word/round counting.
// Define SHAKE_CTRL_UNROLL2_EN for a two-rounds-per-cycle datapath (12-cycle permutation).
module shake_sponge_ctrl #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [OUT_W-1:0] out_words,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             state_clear,
  output logic             absorb_en,
  output logic [4:0]       lane_idx,
  output logic             round_en,
  output logic [4:0]       round_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ABSORB,
    S_PERMUTE,
    S_SQUEEZE,
    S_DONE
  } state_t;

`ifdef SHAKE_CTRL_UNROLL2_EN
  localparam logic [4:0] ROUND_STEP = 5'd2;
  localparam logic [4:0] ROUND_LAST = 5'd22;
`else
  localparam logic [4:0] ROUND_STEP = 5'd1;
  localparam logic [4:0] ROUND_LAST = 5'd23;
`endif

  state_t           state;
  logic [4:0]       rate;
  logic [4:0]       word_cnt;
  logic [4:0]       round_cnt;
  logic [OUT_W-1:0] remaining;
  logic             last_seen;
  logic             squeezing;
  logic             error_q;

  logic rate_end;
  logic in_xfer;
  logic out_xfer;
  logic final_word;

  assign rate_end   = (word_cnt == rate - 5'd1);
  assign in_xfer    = (state == S_ABSORB) && in_valid;
  assign out_xfer   = (state == S_SQUEEZE) && out_ready;
  assign final_word = (remaining == OUT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rate      <= 5'd0;
      word_cnt  <= 5'd0;
      round_cnt <= 5'd0;
      remaining <= '0;
      last_seen <= 1'b0;
      squeezing <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rate      <= mode ? 5'd17 : 5'd21;
            remaining <= (out_words == '0) ? OUT_W'(1) : out_words;
            error_q   <= 1'b0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          word_cnt  <= 5'd0;
          round_cnt <= 5'd0;
          last_seen <= 1'b0;
          squeezing <= 1'b0;
          state     <= S_ABSORB;
        end
        S_ABSORB: begin
          if (in_xfer) begin
            if (rate_end) begin
              word_cnt  <= 5'd0;
              last_seen <= in_last;
              state     <= S_PERMUTE;
            end else begin
              word_cnt <= word_cnt + 5'd1;
              // A last word short of a full block is a framing error; the word still lands.
              if (in_last) begin
                error_q <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end
        end
        S_PERMUTE: begin
          if (round_cnt == ROUND_LAST) begin
            round_cnt <= 5'd0;
            if (squeezing || last_seen) begin
              squeezing <= 1'b1;
              state     <= S_SQUEEZE;
            end else begin
              state <= S_ABSORB;
            end
          end else begin
            round_cnt <= round_cnt + ROUND_STEP;
          end
        end
        S_SQUEEZE: begin
          if (out_xfer) begin
            remaining <= remaining - OUT_W'(1);
            if (final_word) begin
              state <= S_DONE;
            end else if (rate_end) begin
              word_cnt <= 5'd0;
              state    <= S_PERMUTE;
            end else begin
              word_cnt <= word_cnt + 5'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only absorb_en sees an input; everything else decodes registered state.
  assign in_ready    = (state == S_ABSORB);
  assign absorb_en   = in_xfer;
  assign out_valid   = (state == S_SQUEEZE);
  assign out_last    = (state == S_SQUEEZE) && final_word;
  assign state_clear = (state == S_CLEAR);
  assign round_en    = (state == S_PERMUTE);
  assign round_idx   = (state == S_PERMUTE) ? round_cnt : 5'd0;
  assign lane_idx    = ((state == S_ABSORB) || (state == S_SQUEEZE)) ? word_cnt : 5'd0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign error       = error_q;

endmodule

// File: tb/tb_shake_sponge_ctrl.sv
// Directed bench for shake_sponge_ctrl: lane/round sequences, framing error, back-pressure, mid-run reset.
module tb_shake_sponge_ctrl;

  localparam int OUT_W = 16;
`ifdef SHAKE_CTRL_UNROLL2_EN
  localparam int NROUND = 12;
  localparam int RSTEP  = 2;
`else
  localparam int NROUND = 24;
  localparam int RSTEP  = 1;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [OUT_W-1:0] out_words;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             state_clear;
  logic             absorb_en;
  logic [4:0]       lane_idx;
  logic             round_en;
  logic [4:0]       round_idx;
  logic             busy;
  logic             done;
  logic             error;

  int checks_total;
  int checks_passed;
  int done_cnt;

  shake_sponge_ctrl #(.OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .out_words   (out_words),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .state_clear (state_clear),
    .absorb_en   (absorb_en),
    .lane_idx    (lane_idx),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else checks_passed++;
  endtask

  function automatic logic [31:0] flags();
    return 32'({in_ready, out_valid, out_last, state_clear, absorb_en, round_en, busy, done, error});
  endfunction

  // Called at a negedge with the DUT idle; returns at the first ABSORB negedge.
  task automatic start_msg(input bit m, input int ow);
    start     = 1'b1;
    mode      = m;
    out_words = OUT_W'(ow);
    @(negedge clk);
    start = 1'b0;
    chk("clear_pulse", 32'(state_clear), 1);
    chk("clear_busy", 32'(busy), 1);
    chk("start_clears_error", 32'(error), 0);
    chk("clear_no_ready", 32'(in_ready), 0);
    @(negedge clk);
  endtask

  task automatic absorb_block(input int rate, input bit last, input bit stall);
    for (int w = 0; w < rate; w++) begin
      for (int tries = 0; tries < 16; tries++) begin
        logic v;
        v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tries >= 8) v = 1'b1;
        in_valid = v;
        in_last  = last && (w == rate - 1);
        #1;
        chk("absorb_ready", 32'(in_ready), 1);
        chk("absorb_lane", 32'(lane_idx), 32'(w));
        chk("absorb_en", 32'(absorb_en), 32'(v));
        @(negedge clk);
        if (v) break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic permute_phase();
    for (int r = 0; r < NROUND; r++) begin
      chk("round_en", 32'(round_en), 1);
      chk("round_idx", 32'(round_idx), 32'(r * RSTEP));
      chk("permute_no_ready", 32'(in_ready | out_valid), 0);
      @(negedge clk);
    end
  endtask

  task automatic run_msg(input bit m, input int nblk, input int ow, input bit stall);
    int rate;
    int eff;
    int d0;
    rate = m ? 17 : 21;
    eff  = (ow == 0) ? 1 : ow;
    d0   = done_cnt;
    start_msg(m, ow);
    for (int b = 0; b < nblk; b++) begin
      absorb_block(rate, b == nblk - 1, stall);
      permute_phase();
    end
    for (int k = 0; k < eff; k++) begin
      for (int tries = 0; tries < 16; tries++) begin
        logic r;
        r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tries >= 8) r = 1'b1;
        out_ready = r;
        #1;
        chk("sq_valid", 32'(out_valid), 1);
        chk("sq_lane", 32'(lane_idx), 32'(k % rate));
        chk("sq_last", 32'(out_last), 32'(k == eff - 1));
        @(negedge clk);
        if (r) break;
      end
      out_ready = 1'b0;
      if ((k != eff - 1) && (k % rate == rate - 1)) permute_phase();
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_no_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("idle_after_done", flags(), 0);
    chk("done_count", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    done_cnt      = 0;
    rst       = 1'b1;
    start     = 1'b1;
    mode      = 1'b0;
    out_words = '0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", flags(), 0);
    chk("reset_lane", 32'(lane_idx), 0);
    chk("reset_round", 32'(round_idx), 0);
    start     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("idle_flags", flags(), 0);

    run_msg(1'b0, 1, 4, 1'b0);   // single-block SHAKE128
    run_msg(1'b1, 2, 4, 1'b0);   // two-block SHAKE256
    run_msg(1'b1, 1, 20, 1'b0);  // long squeeze crossing a permutation
    run_msg(1'b0, 1, 0, 1'b0);   // zero length squeezes one word

    // Framing error: in_last on word 5 of a SHAKE128 block
    begin
      int d0;
      d0 = done_cnt;
      start_msg(1'b0, 4);
      for (int w = 0; w < 6; w++) begin
        in_valid = 1'b1;
        in_last  = (w == 5);
        #1;
        chk("frame_lane", 32'(lane_idx), 32'(w));
        @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("frame_error", 32'(error), 1);
      chk("frame_idle", 32'(busy | in_ready | round_en), 0);
      repeat (3) @(negedge clk);
      chk("frame_sticky", 32'(error), 1);
      chk("frame_no_done", 32'(done_cnt - d0), 0);
    end
    run_msg(1'b0, 1, 2, 1'b0);   // next start clears error and completes

    run_msg(1'b1, 2, 20, 1'b1);  // back-pressure on both streams
    run_msg(1'b0, 1, 3, 1'b1);

    // Reset during PERMUTE at round_idx 10
    begin
      int d0;
      d0 = done_cnt;
      start_msg(1'b0, 4);
      absorb_block(21, 1'b1, 1'b0);
      while (round_idx != 5'd10 && round_en) @(negedge clk);
      chk("rst_at_round", 32'(round_idx), 10);
      rst = 1'b1;
      #1;
      chk("rst_mid_flags", flags(), 0);
      chk("rst_mid_lane", 32'(lane_idx), 0);
      chk("rst_mid_round", 32'(round_idx), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_after_flags", flags(), 0);
      chk("rst_no_done", 32'(done_cnt - d0), 0);
    end
    run_msg(1'b1, 1, 1, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
